// File: rtl/ifetch_unit.sv
// Instruction fetch front end: issues one memory request at a time and buffers
// returned words with their PCs in a 2-entry FIFO feeding decode.
module ifetch_unit (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic [31:0] pc_in,
    output logic        pc_ena,
    input  logic        redirect,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        imem_req_q;
    logic [31:0] pend_pc_q;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, wr_ptr_q;
    logic [31:0] fifo_pc_q    [2];
    logic [31:0] fifo_instr_q [2];

    logic accept;
    logic push;
    logic pop;

    assign imem_addr = {pc_in[31:2], 2'b00};
    assign imem_req  = imem_req_q;
    assign accept    = imem_req_q & imem_gnt;
    // The PC register must not move while the fetch unit is held in reset.
    assign pc_ena    = ~RST_n & (accept | redirect);

    assign id_valid  = (count_q != 2'd0);
    assign id_instr  = fifo_instr_q[rd_ptr_q];
    assign id_pc     = fifo_pc_q[rd_ptr_q];

    assign push = (state_q == WAIT) & imem_rvalid & ~redirect;
    assign pop  = id_valid & id_ready;

    always_comb begin
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        if (redirect) begin
            count_d = 2'd0;
        end
    end

    // Requests are only issued when a FIFO slot is reserved for the response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (redirect || count_q != 2'd2) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    state_d = imem_gnt ? DROP : REQ;
                end else if (imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    state_d = imem_rvalid ? REQ : DROP;
                end else if (imem_rvalid) begin
                    state_d = (count_d != 2'd2) ? REQ : IDLE;
                end
            end
            DROP: begin
                // A response arriving here is the stale one; once seen, nothing is left to drop.
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST_n) begin
        if (RST_n) begin
            state_q    <= IDLE;
            imem_req_q <= 1'b0;
            pend_pc_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            imem_req_q <= (state_d == REQ);
            if (accept) begin
                pend_pc_q <= pc_in;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST_n) begin
        if (RST_n) begin
            count_q         <= 2'd0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            fifo_pc_q[0]    <= 32'd0;
            fifo_pc_q[1]    <= 32'd0;
            fifo_instr_q[0] <= 32'd0;
            fifo_instr_q[1] <= 32'd0;
        end else begin
            count_q <= count_d;
            if (redirect) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (push) begin
                    fifo_pc_q[wr_ptr_q]    <= pend_pc_q;
                    fifo_instr_q[wr_ptr_q] <= imem_rdata;
                    wr_ptr_q               <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: a memory/PC-register environment model
// predicts which fetched words reach decode and in what order.
module tb_ifetch_unit;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic [31:0] pc_in;
    logic        pc_ena;
    logic        redirect;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    ifetch_unit dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .pc_in      (pc_in),
        .pc_ena     (pc_ena),
        .redirect   (redirect),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] popped_pc[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    int unsigned gnt_pct = 0, rdy_pct = 0, redir_pct = 0, spur_pct = 0;
    int unsigned lat_min = 0, lat_max = 0;
    bit          force_redir = 1'b0;
    logic [31:0] force_tgt = 32'd0;

    logic [31:0] pc_reg = 32'd0;
    logic [31:0] tgt = 32'd0;
    bit          outst = 1'b0;
    bit          stale = 1'b0;
    int unsigned wait_cnt = 0;
    int          epoch = 0, outst_epoch = 0;
    logic [31:0] outst_addr = 32'd0, last_gnt_addr = 32'd0;
    int          grants = 0, delivered = 0;

    logic        s_rst = 1'b1, s_req = 1'b0, s_gnt = 1'b0, s_rvalid = 1'b0;
    logic        s_redir = 1'b0, s_pcena = 1'b0;
    logic [31:0] s_addr = 32'd0, s_tgt = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h8C01_0000;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: samples mid-cycle, compares against the scoreboard head and pops on handshake.
    always @(negedge CLK) begin
        s_rst    = RST_n;
        s_req    = imem_req;
        s_gnt    = imem_gnt;
        s_rvalid = imem_rvalid;
        s_redir  = redirect;
        s_pcena  = pc_ena;
        s_addr   = imem_addr;
        s_tgt    = tgt;
        if (RST_n === 1'b1) begin
            check("rst_pc_ena", pc_ena, 0);
            check("rst_imem_req", imem_req, 0);
            check("rst_id_valid", id_valid, 0);
            check("rst_id_instr", id_instr, 0);
            check("rst_id_pc", id_pc, 0);
        end else begin
            check("id_valid", id_valid, exp_q.size() != 0);
            check("imem_addr", imem_addr, {pc_in[31:2], 2'b00});
            check("pc_ena", pc_ena, (imem_req & imem_gnt) | redirect);
            if (imem_req) begin
                check("req_without_slot", (outst && !stale) || exp_q.size() >= 2, 0);
            end
            if (id_valid && exp_q.size() != 0) begin
                check("id_pc", id_pc, exp_q[0].pc);
                check("id_instr", id_instr, exp_q[0].instr);
                if (id_ready) begin
                    popped_pc.push_back(exp_q[0].pc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Advance one cycle: account for what happened in the cycle just ended, then drive the next.
    task automatic step();
        ent_t e;
        @(posedge CLK);
        if (s_rvalid && outst) begin
            if (!stale && outst_epoch == epoch && !s_redir && !s_rst) begin
                e.pc    = outst_addr;
                e.instr = mem_word(outst_addr);
                exp_q.push_back(e);
                delivered++;
            end
            outst = 1'b0;
            stale = 1'b0;
        end else if (outst && wait_cnt > 0) begin
            wait_cnt--;
        end
        if (s_req && s_gnt && !s_rst) begin
            outst         = 1'b1;
            outst_addr    = s_addr;
            outst_epoch   = epoch;
            wait_cnt      = $urandom_range(lat_max, lat_min);
            last_gnt_addr = s_addr;
            grants++;
        end
        if (s_redir && !s_rst) begin
            epoch++;
            exp_q.delete();
        end
        if (s_pcena) pc_reg = s_redir ? s_tgt : pc_reg + 32'd4;
        #1;
        pc_in    = pc_reg;
        imem_gnt = !outst && ($urandom_range(0, 99) < gnt_pct);
        if (outst) begin
            imem_rvalid = (wait_cnt == 0);
            imem_rdata  = mem_word(outst_addr);
        end else begin
            imem_rvalid = ($urandom_range(0, 99) < spur_pct);
            imem_rdata  = $urandom();
        end
        id_ready = ($urandom_range(0, 99) < rdy_pct);
        if (force_redir) begin
            redirect    = 1'b1;
            tgt         = force_tgt;
            force_redir = 1'b0;
        end else begin
            redirect = ($urandom_range(0, 99) < redir_pct);
            tgt      = $urandom() & 32'hFFFF_FFFC;
        end
    endtask

    task automatic do_reset(input int cycles);
        RST_n = 1'b1;
        exp_q.delete();
        if (outst) stale = 1'b1;
        epoch++;
        #1;
        check("async_rst_req", imem_req, 0);
        check("async_rst_valid", id_valid, 0);
        check("async_rst_pc_ena", pc_ena, 0);
        repeat (cycles) step();
        RST_n = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            step();
            if (exp_q.size() == 0 && !outst) done = 1'b1;
        end
        check(name, done, 1);
    endtask

    initial begin
        int          g0, d0;
        logic [31:0] a0;
        RST_n = 1'b1; pc_in = 32'd0; redirect = 1'b0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'd0; id_ready = 1'b0;
        rdy_pct = 100;
        #1;
        check("init_rst_req", imem_req, 0);
        check("init_rst_pc_ena", pc_ena, 0);
        repeat (3) step();
        RST_n = 1'b0;
        #1;
        check("idle_after_release", imem_req, 0);
        step(); #1;
        check("req_first_edge", imem_req, 1);

        // Streaming from PC 0
        gnt_pct = 100; lat_min = 0; lat_max = 0;
        popped_pc.delete();
        repeat (12) step();
        check("stream_count", popped_pc.size() >= 3, 1);
        if (popped_pc.size() >= 3) begin
            check("stream_pc0", popped_pc[0], 32'h0);
            check("stream_pc1", popped_pc[1], 32'h4);
            check("stream_pc2", popped_pc[2], 32'h8);
        end

        // Backpressure
        rdy_pct = 0;
        repeat (12) step(); #1;
        check("bp_entries", exp_q.size(), 2);
        check("bp_id_valid", id_valid, 1);
        g0 = grants;
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            check("bp_no_req", imem_req, 0);
        end
        check("bp_no_grants", grants - g0, 0);
        rdy_pct = 100; step(); rdy_pct = 0;
        repeat (10) step();
        check("bp_one_refill", grants - g0, 1);
        check("bp_refilled", exp_q.size(), 2);
        gnt_pct = 0; rdy_pct = 100;
        drain("bp_drain");

        // Memory stall
        a0 = pc_reg;
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            check("stall_req", imem_req, 1);
            check("stall_addr", imem_addr, a0);
            check("stall_pc_ena", pc_ena, 0);
        end

        // Redirect while waiting on 0x10
        force_redir = 1'b1; force_tgt = 32'h10;
        step(); step();
        lat_min = 3; lat_max = 3; gnt_pct = 100;
        step(); #1;
        check("wait_grant_addr", imem_addr, 32'h10);
        check("wait_grant_pc_ena", pc_ena, 1);
        gnt_pct = 0; force_redir = 1'b1; force_tgt = 32'h40;
        step(); #1;
        check("wait_redir_pc_ena", pc_ena, 1);
        for (int i = 0; i < 6; i++) begin
            step(); #1;
            check("wait_redir_no_valid", id_valid, 0);
            if (i < 3) check("drop_no_req", imem_req, 0);
        end
        check("wait_resp_consumed", outst, 0);
        check("wait_fifo_empty", exp_q.size(), 0);
        gnt_pct = 100;
        step(); #1;
        check("target_req", imem_req, 1);
        check("target_addr", imem_addr, 32'h40);
        gnt_pct = 0;
        step();
        check("target_granted", last_gnt_addr, 32'h40);
        drain("redir_drain");

        // Redirect coincident with grant
        d0 = delivered;
        gnt_pct = 100; force_redir = 1'b1; force_tgt = 32'h100;
        step(); #1;
        check("gnt_redir_pc_ena", pc_ena, 1);
        gnt_pct = 0;
        step(); #1;
        check("gnt_redir_pc_ena_once", pc_ena, 0);
        check("gnt_redir_drop_req", imem_req, 0);
        for (int i = 0; i < 6; i++) begin
            step(); #1;
            check("gnt_redir_no_valid", id_valid, 0);
        end
        check("gnt_redir_dropped", delivered - d0, 0);
        check("gnt_redir_resp_seen", outst, 0);

        // Reset in the middle of WAIT
        gnt_pct = 100;
        step();
        gnt_pct = 0;
        step();
        do_reset(1);
        for (int i = 0; i < 6; i++) begin
            step(); #1;
            check("mid_wait_rst_no_valid", id_valid, 0);
        end
        check("mid_wait_rst_fifo", exp_q.size(), 0);
        check("mid_wait_rst_resp_seen", outst, 0);

        // Randomised traffic
        d0 = delivered;
        gnt_pct = 70; rdy_pct = 60; redir_pct = 8; spur_pct = 5; lat_min = 0; lat_max = 3;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (i == 2000) do_reset(2);
        end
        check("random_progress", (delivered - d0) > 200, 1);
        gnt_pct = 0; redir_pct = 0; spur_pct = 0; rdy_pct = 100;
        drain("final_drain");
        #1;
        check("final_id_valid", id_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameters: none.
REQ-002 The ports SHALL be exactly as follows:
- CLK  in  1  clock; all state updates on rising edge.
- RST_n  in  1  reset, asynchronous, active-high.
- pc_in  in  32  current value of the PC register.
- pc_ena  out  1  load enable to the PC register.
- redirect  in  1  branch/jump taken; the PC register loads the target when pc_ena=1.
- imem_req  out  1  instruction memory request.
- imem_addr  out  32  request address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- id_valid  out  1  buffered instruction available to decode.
- id_ready  in  1  decode accepts the head entry.
- id_instr  out  32  head instruction.
- id_pc  out  32  PC of the head instruction.

Function
REQ-003 The block SHALL contain a 2-entry FIFO of {pc[31:0], instr[31:0]}, a 2-bit count (0..2) and an FSM with states IDLE, REQ, WAIT and DROP.
REQ-004 imem_addr SHALL equal {pc_in[31:2], 2'b00}, driven combinationally.
REQ-005 imem_req SHALL be 1 only in REQ.
- REQ is entered only when count + outstanding < 2, so every response has a reserved FIFO slot.
REQ-006 Handshake: a request SHALL be accepted when imem_req=1 and imem_gnt=1.
- Accepted request: capture pc_in into a pending-PC register; REQ->WAIT.
- imem_req=1 with imem_gnt=0: remain in REQ with the address held (pc_in unchanged).
REQ-007 pc_ena SHALL be (imem_req & imem_gnt) | redirect, asserted for exactly one cycle per event.
REQ-008 In WAIT, imem_rvalid=1 without redirect SHALL:
- push {pending PC, imem_rdata} into the FIFO;
- go to REQ if space remains after the push, otherwise IDLE.
REQ-009 IDLE SHALL move to REQ on the first cycle with count + outstanding < 2.
- imem_rvalid=1 in IDLE or REQ is ignored.
REQ-010 id_valid SHALL be (count != 0); id_instr and id_pc SHALL show the head entry.
- A pop occurs when id_valid=1 and id_ready=1.
REQ-011 A push and pop in the same cycle SHALL leave count unchanged and keep FIFO order.
- id_ready=1 with count=0 has no effect.
REQ-012 redirect=1 SHALL:
- flush the FIFO (count=0, id_valid=0 next cycle);
- suppress any push in that cycle.
State transitions on redirect:
- WAIT with imem_rvalid=0 -> DROP.
- WAIT with imem_rvalid=1 -> REQ; the data is discarded.
- REQ with imem_gnt=1 -> DROP.
- All other cases -> REQ.
REQ-013 In DROP, imem_req SHALL be 0; the next imem_rvalid=1 is discarded and DROP->REQ. A further redirect in DROP keeps DROP.
REQ-014 Latency: when an imem_rvalid push occurs with count=0, id_valid SHALL be 1 in the following cycle.
REQ-015 At most one memory request SHALL be outstanding at any time.

Reset
REQ-016 While RST_n=1, regardless of CLK:
- state=IDLE, count=0, FIFO pointers=0, pending PC=0;
- outputs imem_req=0, pc_ena=0, id_valid=0, id_instr=0, id_pc=0.
REQ-017 On RST_n deassertion the FSM SHALL leave IDLE for REQ on the first rising edge.
REQ-018 An imem_rvalid arriving after a mid-WAIT reset SHALL be ignored.

Verification
REQ-019 Streaming: pc_in=0x00000000, gnt=1 always, rvalid one cycle after each grant, id_ready=1 -> id_pc sequence 0x0,0x4,0x8 with pc_ena pulsing once per grant.
REQ-020 Backpressure: id_ready=0, 3 fetches available -> exactly 2 entries buffered, imem_req=0 afterwards; one pop -> exactly one new request issued.
REQ-021 Redirect in WAIT: redirect=1 while waiting on 0x00000010 -> response 0x8C010000 discarded, FIFO empty, next request addr = target 0x00000040.
REQ-022 Redirect coincident with gnt -> pc_ena=1 for one cycle, state DROP, the following rvalid is dropped, no id_valid for that word.
REQ-023 Memory stall: gnt=0 for 5 cycles -> imem_req=1 and imem_addr stable throughout, pc_ena=0 throughout.
REQ-024 Mid-WAIT reset: RST_n=1 pulse, then rvalid=1 -> all outputs 0, FIFO stays empty.
